// File: rtl/code_loader_if.sv
// code_loader_if: byte-stream handshake into the code loader.
// A byte moves on a clock where in_valid and in_ready are both high.
interface code_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/code_loader.sv
// code_loader: fills the 256-byte program image from a length-prefixed byte
// stream and holds the CPU in reset until a complete image is in place.
// Define CODE_LOADER_CHECKSUM_EN to expect a trailing sum-mod-256 byte.
//
// state | meaning
// IDLE  | no load in progress (after reset or a failed checksum)
// LEN   | waiting for the length header; 0 means 256 bytes
// DATA  | writing code bytes, remaining counts down to the last one
// CSUM  | waiting for the checksum byte (checksum build only)
// DONE  | image complete, CPU released, held until the next start
module code_loader #(
  parameter int IMG_BYTES = 256,
  parameter int ADDR_W    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  code_loader_if.slave           bus,
  output logic [IMG_BYTES*8-1:0] code,
  output logic                   cpu_reset,
  output logic [ADDR_W-1:0]      load_addr,
  output logic                   done,
  output logic                   error
);

`ifdef CODE_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, LEN, DATA, DONE} state_t;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W:0]   remaining_q;
  logic              ready_q;
  logic              active_d;
  logic              xfer;
  logic              last_byte;

  assign xfer      = bus.in_valid & ready_q;
  assign last_byte = (remaining_q == (ADDR_W+1)'(1));
  assign bus.in_ready = ready_q;
  assign done      = (state_q == DONE);
  assign cpu_reset = (state_q != DONE);

`ifdef CODE_LOADER_CHECKSUM_EN
  logic [7:0] sum_q;
  logic       error_q;
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state; start overrides any transfer in the same cycle.
  always_comb begin
    state_d  = state_q;
    active_d = 1'b0;
    if (start) begin
      state_d = LEN;
    end else begin
      case (state_q)
        IDLE: ;
        LEN:  if (xfer) state_d = DATA;
`ifdef CODE_LOADER_CHECKSUM_EN
        DATA: if (xfer && last_byte) state_d = CSUM;
        CSUM: if (xfer) state_d = (sum_q == bus.in_data) ? DONE : IDLE;
`else
        DATA: if (xfer && last_byte) state_d = DONE;
`endif
        DONE: ;
        default: state_d = IDLE;
      endcase
    end
    case (state_d)
      LEN, DATA: active_d = 1'b1;
`ifdef CODE_LOADER_CHECKSUM_EN
      CSUM:      active_d = 1'b1;
`endif
      default:   active_d = 1'b0;
    endcase
  end

  // Image, write pointer, byte countdown and registered ready level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      code        <= '0;
      load_addr   <= '0;
      remaining_q <= '0;
      ready_q     <= 1'b0;
    end else begin
      ready_q <= active_d;
      if (start) begin
        code        <= '0;
        load_addr   <= '0;
        remaining_q <= '0;
      end else if (xfer) begin
        case (state_q)
          LEN: remaining_q <= (bus.in_data == 8'd0) ? (ADDR_W+1)'(IMG_BYTES)
                                                    : (ADDR_W+1)'(bus.in_data);
          DATA: begin
            code[{load_addr, 3'b000} +: 8] <= bus.in_data;
            load_addr   <= load_addr + 1'b1;
            remaining_q <= remaining_q - 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef CODE_LOADER_CHECKSUM_EN
  // Running sum of data bytes and sticky mismatch flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q   <= '0;
      error_q <= 1'b0;
    end else if (start) begin
      sum_q   <= '0;
      error_q <= 1'b0;
    end else if (xfer) begin
      if (state_q == DATA) sum_q <= sum_q + bus.in_data;
      if (state_q == CSUM && sum_q != bus.in_data) error_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_code_loader.sv
// tb_code_loader: randomized stream stimulus checked against a byte-array
// image model of the loader.
`timescale 1ns/1ps
module tb_code_loader;
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [2047:0] code;
  logic          cpu_reset;
  logic [7:0]    load_addr;
  logic          done;
  logic          error;

  code_loader_if bus();

  code_loader dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus.slave),
    .code(code), .cpu_reset(cpu_reset), .load_addr(load_addr),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  logic [7:0] img [256];
  int         exp_addr;
  logic       exp_done;
  logic       exp_err;
  logic       done_pre;
  logic [7:0] data_q [$];
  logic [7:0] stream_q [$];

  function automatic logic [2047:0] exp_code();
    logic [2047:0] v;
    for (int n = 0; n < 256; n++) v[n*8 +: 8] = img[n];
    return v;
  endfunction

  function automatic int first_diff();
    for (int n = 0; n < 256; n++) if (code[n*8 +: 8] !== img[n]) return n;
    return 0;
  endfunction

  task automatic model_clear();
    for (int n = 0; n < 256; n++) img[n] = 8'h00;
    exp_addr = 0;
    exp_done = 1'b0;
    exp_err  = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_clear();
  endtask

  task automatic drive_stream(input bit rand_valid);
    int   idx;
    int   cyc;
    logic rdy;
    idx = 0;
    cyc = 0;
    while (idx < stream_q.size() && cyc < 4000) begin
      @(negedge clk);
      bus.in_valid = rand_valid ? ($urandom_range(0, 1) == 1) : 1'b1;
      bus.in_data  = stream_q[idx];
      rdy          = bus.in_ready;
      done_pre     = done;
      @(posedge clk);
      if (bus.in_valid && rdy) idx++;
      cyc++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
    checks++;
    if (idx != stream_q.size())
      $display("FAIL stream_accept: accepted %0d bytes, required %0d", idx, stream_q.size());
    else passed++;
  endtask

  task automatic run_load(input logic [7:0] hdr, input bit rand_valid, input bit bad_csum);
    int sum;
    sum = 0;
    stream_q.delete();
    stream_q.push_back(hdr);
    foreach (data_q[i]) begin
      stream_q.push_back(data_q[i]);
      img[exp_addr] = data_q[i];
      exp_addr = (exp_addr + 1) % 256;
      sum += int'(data_q[i]);
    end
`ifdef CODE_LOADER_CHECKSUM_EN
    stream_q.push_back(bad_csum ? 8'(sum + 1) : 8'(sum));
    exp_done = !bad_csum;
    exp_err  = bad_csum;
`else
    exp_done = 1'b1;
    exp_err  = 1'b0;
    if (bad_csum) $display("note: checksum disabled, bad checksum request has no effect");
`endif
    drive_stream(rand_valid);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    model_clear();
    checks++; if (code !== exp_code()) $display("FAIL reset_code: byte %0d is %h, required 00", first_diff(), code[first_diff()*8 +: 8]); else passed++;
    checks++; if (bus.in_ready !== 1'b0) $display("FAIL reset_ready: got %b, required 0", bus.in_ready); else passed++;
    checks++; if (cpu_reset !== 1'b1) $display("FAIL reset_cpu_reset: got %b, required 1", cpu_reset); else passed++;
    checks++; if (done !== 1'b0 || error !== 1'b0) $display("FAIL reset_flags: done %b error %b, required 0 0", done, error); else passed++;
    checks++; if (load_addr !== 8'd0) $display("FAIL reset_addr: got %0d, required 0", load_addr); else passed++;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_basic();
    do_start();
    data_q = '{8'h01, 8'h00, 8'h05};
    run_load(8'h03, 1'b0, 1'b0);
    checks++; if (done_pre !== 1'b0) $display("FAIL basic_done_early: got %b, required 0", done_pre); else passed++;
    checks++; if (done !== exp_done || cpu_reset !== !exp_done) $display("FAIL basic_done: done %b cpu_reset %b, required %b %b", done, cpu_reset, exp_done, !exp_done); else passed++;
    checks++; if (code[23:0] !== 24'h050001) $display("FAIL basic_low_bytes: got %h, required 050001", code[23:0]); else passed++;
    checks++; if (code !== exp_code()) $display("FAIL basic_code: byte %0d is %h, required %h", first_diff(), code[first_diff()*8 +: 8], img[first_diff()]); else passed++;
    checks++; if (load_addr !== 8'(exp_addr)) $display("FAIL basic_addr: got %0d, required %0d", load_addr, exp_addr); else passed++;
    checks++; if (bus.in_ready !== 1'b0) $display("FAIL basic_ready_done: got %b, required 0", bus.in_ready); else passed++;
  endtask

  task automatic test_ignore_in_done();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom_range(1, 255));
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++; if (code !== exp_code()) $display("FAIL ignore_code: byte %0d is %h, required %h", first_diff(), code[first_diff()*8 +: 8], img[first_diff()]); else passed++;
    checks++; if (load_addr !== 8'(exp_addr) || done !== 1'b1) $display("FAIL ignore_state: addr %0d done %b, required %0d 1", load_addr, done, exp_addr); else passed++;
  endtask

  task automatic test_full_image();
    do_start();
    data_q.delete();
    for (int n = 0; n < 256; n++) data_q.push_back(8'(n));
    run_load(8'h00, 1'b0, 1'b0);
    checks++; if (code !== exp_code()) $display("FAIL full_code: byte %0d is %h, required %h", first_diff(), code[first_diff()*8 +: 8], img[first_diff()]); else passed++;
    checks++; if (load_addr !== 8'd0) $display("FAIL full_addr_wrap: got %0d, required 0", load_addr); else passed++;
    checks++; if (done !== exp_done) $display("FAIL full_done: got %b, required %b", done, exp_done); else passed++;
  endtask

  task automatic test_random_valid();
    for (int it = 0; it < 4; it++) begin
      int len;
      do_start();
      data_q.delete();
      if (it == 0) begin
        data_q = '{8'h01, 8'h00, 8'h05};
        len = 3;
      end else begin
        len = $urandom_range(1, 64);
        for (int i = 0; i < len; i++) data_q.push_back(8'($urandom));
      end
      run_load(8'(len), 1'b1, 1'b0);
      checks++; if (code !== exp_code()) $display("FAIL random_code[%0d]: byte %0d is %h, required %h", it, first_diff(), code[first_diff()*8 +: 8], img[first_diff()]); else passed++;
      checks++; if (load_addr !== 8'(exp_addr) || done !== exp_done) $display("FAIL random_state[%0d]: addr %0d done %b, required %0d %b", it, load_addr, done, exp_addr, exp_done); else passed++;
    end
  endtask

  task automatic test_abort();
    do_start();
    stream_q = '{8'h05, 8'h11, 8'h22};
    drive_stream(1'b0);
    checks++; if (load_addr !== 8'd2) $display("FAIL abort_partial_addr: got %0d, required 2", load_addr); else passed++;
    @(negedge clk);
    start = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h77;
    @(negedge clk);
    start = 1'b0;
    bus.in_valid = 1'b0;
    model_clear();
    checks++; if (load_addr !== 8'd0 || code !== exp_code()) $display("FAIL abort_cleared: addr %0d byte %0d is %h, required 0 and 00", load_addr, first_diff(), code[first_diff()*8 +: 8]); else passed++;
    checks++; if (bus.in_ready !== 1'b1 || done !== 1'b0) $display("FAIL abort_relaunch: ready %b done %b, required 1 0", bus.in_ready, done); else passed++;
    data_q = '{8'hAA};
    run_load(8'h01, 1'b0, 1'b0);
    checks++; if (code !== exp_code()) $display("FAIL abort_code: byte %0d is %h, required %h", first_diff(), code[first_diff()*8 +: 8], img[first_diff()]); else passed++;
    checks++; if (done !== exp_done) $display("FAIL abort_done: got %b, required %b", done, exp_done); else passed++;
  endtask

  task automatic test_restart_from_done();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (cpu_reset !== 1'b1 || done !== 1'b0) $display("FAIL restart_release: cpu_reset %b done %b, required 1 0", cpu_reset, done); else passed++;
    checks++; if (code !== '0) $display("FAIL restart_clear: byte %0d nonzero", first_diff()); else passed++;
    @(negedge clk);
    start = 1'b0;
    model_clear();
  endtask

  task automatic test_async_reset();
    do_start();
    stream_q = '{8'h04, 8'h12, 8'h34};
    drive_stream(1'b0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    model_clear();
    checks++; if (code !== exp_code()) $display("FAIL async_code: byte %0d is %h, required 00", first_diff(), code[first_diff()*8 +: 8]); else passed++;
    checks++; if (bus.in_ready !== 1'b0 || cpu_reset !== 1'b1 || done !== 1'b0) $display("FAIL async_outputs: ready %b cpu_reset %b done %b, required 0 1 0", bus.in_ready, cpu_reset, done); else passed++;
    checks++; if (load_addr !== 8'd0) $display("FAIL async_addr: got %0d, required 0", load_addr); else passed++;
    @(negedge clk);
    reset = 1'b1;
  endtask

`ifdef CODE_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    do_start();
    data_q = '{8'h01, 8'h02};
    run_load(8'h02, 1'b0, 1'b0);
    checks++; if (done !== 1'b1 || error !== 1'b0) $display("FAIL csum_good: done %b error %b, required 1 0", done, error); else passed++;
    do_start();
    data_q = '{8'h01, 8'h02};
    run_load(8'h02, 1'b0, 1'b1);
    checks++; if (error !== 1'b1 || done !== 1'b0 || cpu_reset !== 1'b1) $display("FAIL csum_bad: error %b done %b cpu_reset %b, required 1 0 1", error, done, cpu_reset); else passed++;
    checks++; if (code !== exp_code()) $display("FAIL csum_image_kept: byte %0d is %h, required %h", first_diff(), code[first_diff()*8 +: 8], img[first_diff()]); else passed++;
    do_start();
    checks++; if (error !== 1'b0) $display("FAIL csum_clear: error %b, required 0", error); else passed++;
  endtask
`endif

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    model_clear();
    test_reset();
    test_basic();
    test_ignore_in_done();
    test_restart_from_done();
    test_full_image();
    test_random_valid();
    test_abort();
    test_async_reset();
`ifdef CODE_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, checks);
    $fatal(1);
  end
endmodule
